// File: rtl/line_window_3x3.sv
// line_window_3x3: streaming 3x3 neighbourhood generator for an RGB565 pixel
// stream. Two line RAMs hold the previous two rows; a small column shift
// register plus the incoming column form a row-major window (data00..data22,
// data11 = centre). One window per accepted pixel once the window lies fully
// inside the frame; no padded border windows are produced.
//
// Optional feature: define LINE_WINDOW_COORD_EN to add win_x/win_y outputs
// carrying the centre coordinates of each window.
module line_window_3x3 #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic [DW-1:0]              pixel_in,
  input  logic                       pixel_valid,
  output logic [9*DW-1:0]            win_o,
  output logic                       win_valid,
  output logic                       frame_done
`ifdef LINE_WINDOW_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0]   win_x,
  output logic [$clog2(IMG_H)-1:0]   win_y
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [XW-1:0]   cur_x;
  logic [YW-1:0]   cur_y;
  logic            accept;
  logic            last_px;

  // Line RAMs: lb0 holds row y-1, lb1 holds row y-2 (never reset)
  logic [DW-1:0]   lb0 [IMG_W];
  logic [DW-1:0]   lb1 [IMG_W];

  // Stage 0: accepted pixel plus the synchronous RAM read of its column
  logic            vld_p0;
  logic            gate_p0;
  logic            last_p0;
  logic [DW-1:0]   pix_p0;
  logic [DW-1:0]   rd0_p0;
  logic [DW-1:0]   rd1_p0;
`ifdef LINE_WINDOW_COORD_EN
  logic [XW-1:0]   x_p0;
  logic [YW-1:0]   y_p0;
  logic [XW-1:0]   win_x_q, win_x_d;
  logic [YW-1:0]   win_y_q, win_y_d;
`endif

  // Stage 1: the two older columns; the third column is the incoming one
  logic [3*DW-1:0] col1_q, col1_d;
  logic [3*DW-1:0] col2_q, col2_d;
  logic [9*DW-1:0] win_asm;
  logic [9*DW-1:0] win_q, win_d;
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;

  // Frame FSM and pixel coordinate counters (next-state logic)
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cur_x   = x_q;
    cur_y   = y_q;
    if (frame_start) begin
      state_d = ACTIVE;
      cur_x   = '0;
      cur_y   = '0;
      x_d     = '0;
      y_d     = '0;
    end
    // A pixel coinciding with frame_start is pixel (0,0) of the new frame
    accept  = pixel_valid && (frame_start || (state_q == ACTIVE));
    last_px = accept && (cur_x == X_LAST) && (cur_y == Y_LAST);
    if (accept) begin
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
      end else begin
        x_d = cur_x + 1'b1;
      end
    end
    if (last_px) state_d = DONE;
  end

  // FSM state and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Line RAM read-before-write: rows shift down one buffer per accepted pixel
  always_ff @(posedge clk) begin
    if (accept) begin
      rd0_p0     <= lb0[cur_x];
      rd1_p0     <= lb1[cur_x];
      lb1[cur_x] <= lb0[cur_x];
      lb0[cur_x] <= pixel_in;
    end
  end

  // Stage 0 control: valid, in-frame window gate, last-pixel flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      gate_p0 <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= accept;
      gate_p0 <= (cur_x >= XW'(2)) && (cur_y >= YW'(2));
      last_p0 <= last_px;
    end
  end

  // Stage 0 data: the accepted pixel (and its coordinates when enabled)
  always_ff @(posedge clk) begin
    if (accept) begin
      pix_p0 <= pixel_in;
`ifdef LINE_WINDOW_COORD_EN
      x_p0   <= cur_x;
      y_p0   <= cur_y;
`endif
    end
  end

  // Stage 1: column shift and window assembly; frame_start squashes the
  // in-flight pixel of the old frame and clears the columns
  always_comb begin
    win_asm = {col1_q[3*DW-1 -: DW], col2_q[3*DW-1 -: DW], rd1_p0,
               col1_q[2*DW-1 -: DW], col2_q[2*DW-1 -: DW], rd0_p0,
               col1_q[DW-1:0],       col2_q[DW-1:0],       pix_p0};
    col1_d = col1_q;
    col2_d = col2_q;
    if (frame_start) begin
      col1_d = '0;
      col2_d = '0;
    end else if (vld_p0) begin
      col1_d = col2_q;
      col2_d = {rd1_p0, rd0_p0, pix_p0};
    end
    win_valid_d  = vld_p0 && gate_p0 && !frame_start;
    frame_done_d = vld_p0 && last_p0 && !frame_start;
    win_d        = win_valid_d ? win_asm : win_q;
`ifdef LINE_WINDOW_COORD_EN
    win_x_d = win_valid_d ? x_p0 - 1'b1 : win_x_q;
    win_y_d = win_valid_d ? y_p0 - 1'b1 : win_y_q;
`endif
  end

  // Column registers (cleared by frame_start, not by reset)
  always_ff @(posedge clk) begin
    col1_q <= col1_d;
    col2_q <= col2_d;
  end

  // Output registers: window holds its value between valid pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef LINE_WINDOW_COORD_EN
      win_x_q      <= '0;
      win_y_q      <= '0;
`endif
    end else begin
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
`ifdef LINE_WINDOW_COORD_EN
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
`endif
    end
  end

  assign win_o      = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
`ifdef LINE_WINDOW_COORD_EN
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
`endif

endmodule

// File: tb/tb_line_window_3x3.sv
// Testbench for line_window_3x3 on a 4x4 image, pixel value = base + 16*y + x.
// Stimulus is a per-cycle record table; each record's expected outputs are
// the response to the previous record's inputs (one-cycle latency).
module tb_line_window_3x3;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;
  localparam int WW = 9 * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          pixel_valid;
  logic [DW-1:0] pixel_in;
  logic [WW-1:0] win_o;
  logic          win_valid;
  logic          frame_done;
`ifdef LINE_WINDOW_COORD_EN
  logic [1:0]    win_x;
  logic [1:0]    win_y;
`endif

  always #5 clk = ~clk;

  line_window_3x3 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .win_o       (win_o),
    .win_valid   (win_valid),
    .frame_done  (frame_done)
`ifdef LINE_WINDOW_COORD_EN
    ,
    .win_x       (win_x),
    .win_y       (win_y)
`endif
  );

  typedef struct {
    logic          fs;
    logic          pv;
    logic [DW-1:0] pix;
    logic          ev;
    logic          ed;
    logic [WW-1:0] ew;
    logic [1:0]    ex;
    logic [1:0]    ey;
  } vec_t;

  vec_t          vec[$];
  int            checks   = 0;
  int            failures = 0;
  int            n_valid  = 0;

  // Expectation pending for the next record (window value held between pulses)
  logic          nv, nd;
  logic [WW-1:0] nw;
  logic [1:0]    nx, ny;

  function automatic logic [WW-1:0] win_of(input int base, input int cx, input int cy);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(8 - (3*r + c))*DW +: DW] = DW'(base + 16*(cy - 1 + r) + (cx - 1 + c));
    return w;
  endfunction

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    nv = 1'b0; nd = 1'b0; nw = '0; nx = '0; ny = '0;
  endtask

  task automatic push(input logic fs, input logic pv, input logic [DW-1:0] pix,
                      input logic v, input logic d, input int base, input int cx, input int cy);
    vec_t e;
    e.fs = fs; e.pv = pv; e.pix = pix;
    e.ev = nv; e.ed = nd; e.ew = nw; e.ex = nx; e.ey = ny;
    vec.push_back(e);
    nv = v;
    nd = d;
    if (v) begin
      nw = win_of(base, cx, cy);
      nx = 2'(cx);
      ny = 2'(cy);
    end
  endtask

  task automatic push_pixel(input logic fs, input int base, input int x, input int y);
    push(fs, 1'b1, DW'(base + 16*y + x), (x >= 2) && (y >= 2),
         (x == W-1) && (y == H-1), base, x - 1, y - 1);
  endtask

  task automatic push_idle(input logic fs, input logic pv, input logic [DW-1:0] pix);
    push(fs, pv, pix, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic run_table(input string tag);
    foreach (vec[i]) begin
      frame_start = vec[i].fs;
      pixel_valid = vec[i].pv;
      pixel_in    = vec[i].pix;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].win_valid", tag, i), WW'(win_valid), WW'(vec[i].ev));
      chk($sformatf("%s[%0d].frame_done", tag, i), WW'(frame_done), WW'(vec[i].ed));
      chk($sformatf("%s[%0d].win_o", tag, i), win_o, vec[i].ew);
`ifdef LINE_WINDOW_COORD_EN
      chk($sformatf("%s[%0d].win_x", tag, i), WW'(win_x), WW'(vec[i].ex));
      chk($sformatf("%s[%0d].win_y", tag, i), WW'(win_y), WW'(vec[i].ey));
`endif
      if (win_valid === 1'b1) n_valid++;
    end
    vec.delete();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
  endtask

  task automatic push_frame(input int base);
    push_idle(1'b1, 1'b0, '0);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        push_pixel(1'b0, base, x, y);
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.win_valid", WW'(win_valid), '0);
    chk("reset.frame_done", WW'(frame_done), '0);
    chk("reset.win_o", win_o, '0);
    reset = 1'b0;

    // Pixels while IDLE are ignored
    for (int i = 0; i < 3; i++) push_idle(1'b0, 1'b1, 16'hABCD);
    push_idle(1'b0, 1'b0, '0);
    run_table("idle");

    // Contiguous frame, then pixels after DONE are ignored
    push_frame(0);
    push_idle(1'b0, 1'b1, 16'h5555);
    push_idle(1'b0, 1'b1, 16'h5555);
    push_idle(1'b0, 1'b0, '0);
    n_valid = 0;
    run_table("full");
    chk("full.window_count", WW'(n_valid), WW'(4));
    // Spot-check the first window against hand values 00/11/22
    chk("first.data00", WW'(win_of(0, 1, 1) >> (8*DW)), WW'(16'h0000));
    chk("first.data22", WW'(win_of(0, 1, 1) & 144'hFFFF), WW'(16'h0022));

    // Same frame with one idle cycle after every pixel
    push_idle(1'b1, 1'b0, '0);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        push_pixel(1'b0, 0, x, y);
        push_idle(1'b0, 1'b0, 16'h7777);
      end
    n_valid = 0;
    run_table("gap");
    chk("gap.window_count", WW'(n_valid), WW'(4));

    // Frame A aborted at pixel (1,2); frame B (+0x100) starts on that cycle
    push_idle(1'b1, 1'b0, '0);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < W; x++)
        push_pixel(1'b0, 0, x, y);
    push_pixel(1'b0, 0, 0, 2);
    push_pixel(1'b1, 16'h100, 0, 0);
    for (int p = 1; p < W*H; p++) push_pixel(1'b0, 16'h100, p % W, p / W);
    push_idle(1'b0, 1'b0, '0);
    n_valid = 0;
    run_table("restart");
    chk("restart.window_count", WW'(n_valid), WW'(4));

    // Reset mid-frame right after pixel (3,2) is accepted
    push_idle(1'b1, 1'b0, '0);
    for (int p = 0; p <= 11; p++) push_pixel(1'b0, 0, p % W, p / W);
    run_table("prereset");
    #2;
    reset = 1'b1;
    #1;
    chk("midreset.win_valid", WW'(win_valid), '0);
    chk("midreset.frame_done", WW'(frame_done), '0);
    chk("midreset.win_o", win_o, '0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) push_idle(1'b0, 1'b1, 16'h1234);
    push_frame(16'h300);
    push_idle(1'b0, 1'b0, '0);
    n_valid = 0;
    run_table("postreset");
    chk("postreset.window_count", WW'(n_valid), WW'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_window_3x3.md
# line_window_3x3

- Streaming 3x3 neighbourhood generator between the camera pixel stream (RGB565) and the per-pixel filter stages (gray-scale, edge, motion).
- Buffers two image rows in on-chip line RAMs and assembles a 3x3 window row-major, data00..data22, with data11 as centre.
- Emits one window per accepted pixel once the window lies fully inside the frame; no padding windows.

## Interface
- IMG_W, 320, active pixels per line
- IMG_H, 240, active lines per frame
- DW, 16, pixel width (RGB565)
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse; next accepted pixel is (0,0)
- pixel_in  in  DW  pixel data, sampled when pixel_valid=1
- pixel_valid  in  1  pixel_in valid this cycle; no backpressure
- win_o  out  9*DW  window, row-major: data00 at [9*DW-1 -: DW] … data22 at [DW-1:0]
- win_valid  out  1  win_o valid this cycle (one-cycle pulse per window)
- frame_done  out  1  one-cycle pulse after last pixel (IMG_W-1, IMG_H-1) accepted

## Operation
- FSM: IDLE, ACTIVE, DONE.
  - Reset -> IDLE.
  - IDLE/DONE + frame_start -> ACTIVE, x=y=0.
  - ACTIVE + last pixel accepted -> DONE.
  - pixel_valid ignored in IDLE and DONE.
  - frame_start in ACTIVE restarts the frame: counters cleared, window column registers cleared.
- Counters x (0..IMG_W-1, wraps, increments y) and y (0..IMG_H-1), advancing only on accepted pixels.
- Line buffers lb0 (row y-1), lb1 (row y-2), depth IMG_W, DW wide; one read and one write per accepted pixel at address x.
  - Accepted pixel p at (x,y): column {lb1[x], lb0[x], p} shifts into 3-column register.
  - Write lb1[x]<=old lb0[x], lb0[x]<=p.
  - RAM contents not cleared by reset or frame_start; rows y<2 never feed a valid window.
- Window after pixel (x,y): centre (x-1,y-1); top row y-2, left column x-2.
- win_valid=1 only for pixels with x>=2 and y>=2; (IMG_W-2)*(IMG_H-2) windows per frame.
- Column registers continue across line wrap; the x>=2 gate suppresses mixed-line windows.
- frame_start and pixel_valid in same cycle: pixel accepted as (0,0) of the new frame.
- Gaps in pixel_valid: all state holds; no time-outs.

## Timing
- Reset: win_o=0, win_valid=0, frame_done=0, x=y=0, state IDLE.
- Latency: pixel accepted at edge N -> win_o/win_valid registered, visible after edge N+1 (one cycle).
- win_o holds its last value while win_valid=0.
- frame_done pulses in the same cycle as the final win_valid.
- Throughput: one pixel per clock sustained.
- Line RAM read is synchronous; read-before-write at the same address.
- Reset asserted mid-frame: outputs clear immediately (asynchronous); a frame_start is required before new pixels are accepted.

## Configuration
- LINE_WINDOW_COORD_EN defined: adds outputs win_x (clog2(IMG_W) bits) and win_y (clog2(IMG_H) bits).
  - Both carry centre coordinates (x-1,y-1), registered alongside win_o; reset 0.
- Not defined: ports and coordinate registers absent; all other behaviour identical.

## Test plan
Bench uses IMG_W=4, IMG_H=4, DW=16, pixel value = 16*y + x.
- Reset, frame_start, 16 contiguous pixels -> 4 win_valid pulses.
  - First window (centre 1,1), one cycle after pixel (2,2): data00=0x00, data11=0x11, data22=0x22.
  - Last window: data22=0x33; frame_done coincident with it.
- Same frame with pixel_valid toggled 1/0 every cycle -> identical 4 windows in same order; state holds during gaps.
- pixel_valid pulses in IDLE, and after DONE before frame_start -> no win_valid, counters stay 0.
- frame_start asserted at pixel (1,2) of frame A, then full frame B with values +0x100 -> exactly 4 windows, all from frame B: first data11=0x111.
- Reset pulsed mid-frame after pixel (3,2) -> win_valid/win_o 0 immediately; pixels before next frame_start ignored.
- With LINE_WINDOW_COORD_EN: win_x/win_y sequence (1,1),(2,1),(1,2),(2,2) matching win_valid.
